// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one registered-read memory port between reqNum requesters.
// Optional same-cycle write-to-read forwarding enabled by defining MEM_ARB_RAW_BYPASS_EN.
module mem_rd_arbiter #(
  parameter  int reqNum      = 4,
  parameter  int elementsNum = 4,
  parameter  int dataWidth   = 4,
  localparam int AW          = $clog2(elementsNum),
  localparam int IW          = $clog2(reqNum)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [reqNum-1:0]    req,
  input  logic [reqNum*AW-1:0] req_addr,
  output logic [reqNum-1:0]    gnt,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [dataWidth-1:0] wr_data,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_wraddr,
  output logic [dataWidth-1:0] mem_wrdata,
  output logic [AW-1:0]        mem_rdaddr,
  input  logic [dataWidth-1:0] mem_rddata,
  output logic                 rsp_valid,
  output logic [IW-1:0]        rsp_id,
  output logic [dataWidth-1:0] rsp_data
);

  logic [IW-1:0]     r_ptr;
  logic              r_vld;
  logic [IW-1:0]     r_id;
  logic              w_any;
  logic [IW-1:0]     w_win;
  logic [IW:0]       w_idx;
  logic [reqNum-1:0] w_gnt;
  logic [AW-1:0]     w_rdaddr;

  // Walk requesters starting at r_ptr; the extra index bit absorbs the wrap before the modulo.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 0; k < reqNum; k++) begin
      w_idx = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(reqNum)) w_idx = w_idx - (IW+1)'(reqNum);
      if (!w_any && req[w_idx[IW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[IW-1:0];
      end
    end
    if (!rst_n) w_any = 1'b0;
  end

  always_comb begin
    w_gnt    = '0;
    w_rdaddr = '0;
    if (w_any) begin
      w_gnt[w_win] = 1'b1;
      w_rdaddr     = req_addr[int'(w_win)*AW +: AW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_vld <= 1'b0;
      r_id  <= '0;
    end else begin
      r_vld <= w_any;
      if (w_any) begin
        r_ptr <= (w_win == IW'(reqNum-1)) ? '0 : w_win + 1'b1;
        r_id  <= w_win;
      end
    end
  end

`ifdef MEM_ARB_RAW_BYPASS_EN
  logic                 r_byp_vld;
  logic [dataWidth-1:0] r_byp_q;
  logic                 w_raw_hit;

  assign w_raw_hit = w_any && wr_en && (wr_addr == w_rdaddr);

  // Capture the colliding write so the response sees NEW data instead of the memory's OLD word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp_vld <= 1'b0;
      r_byp_q   <= '0;
    end else begin
      r_byp_vld <= w_raw_hit;
      if (w_raw_hit) r_byp_q <= wr_data;
    end
  end

  assign rsp_data = r_byp_vld ? r_byp_q : mem_rddata;
`else
  assign rsp_data = mem_rddata;
`endif

  assign gnt        = w_gnt;
  assign mem_rdaddr = w_rdaddr;
  assign mem_we     = wr_en;
  assign mem_wraddr = wr_addr;
  assign mem_wrdata = wr_data;
  assign rsp_valid  = r_vld;
  assign rsp_id     = r_id;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter with a 1-cycle registered-read memory model.
module tb_mem_rd_arbiter;
  localparam int RN = 4;
  localparam int EN = 4;
  localparam int DW = 4;
  localparam int AW = 2;
  localparam int IW = 2;

  logic              clk;
  logic              rst_n;
  logic [RN-1:0]     req;
  logic [RN*AW-1:0]  req_addr;
  logic [RN-1:0]     gnt;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              mem_we;
  logic [AW-1:0]     mem_wraddr;
  logic [DW-1:0]     mem_wrdata;
  logic [AW-1:0]     mem_rdaddr;
  logic [DW-1:0]     mem_rddata;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data;

  logic [DW-1:0] mem [EN];
  int n_chk = 0;
  int n_bad = 0;

  mem_rd_arbiter #(.reqNum(RN), .elementsNum(EN), .dataWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_we(mem_we), .mem_wraddr(mem_wraddr), .mem_wrdata(mem_wrdata),
    .mem_rdaddr(mem_rdaddr), .mem_rddata(mem_rddata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-before-write memory: a same-cycle read returns the old word.
  always @(posedge clk) begin
    if (mem_we) mem[mem_wraddr] <= mem_wrdata;
    mem_rddata <= mem[mem_rdaddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RN*AW-1:0] pk(input logic [AW-1:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  initial begin
    logic [DW-1:0] col_exp;
`ifdef MEM_ARB_RAW_BYPASS_EN
    col_exp = 4'h5;
`else
    col_exp = 4'h3;
`endif
    rst_n = 1'b0; req = 4'b1111; req_addr = pk(2'd1, 2'd3, 2'd2, 2'd0);
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_ptr", 32'(dut.r_ptr), 32'h0);

    // preload mem[2]=A, mem[1]=3 through the passthrough write port
    step(); rst_n = 1'b1; req = '0; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'hA;
    @(negedge clk);
    chk("wr_we", 32'(mem_we), 32'h1);
    chk("wr_addr", 32'(mem_wraddr), 32'h2);
    chk("wr_data", 32'(mem_wrdata), 32'hA);
    step(); wr_addr = 2'd1; wr_data = 4'h3;
    step(); wr_en = 1'b0;

    // idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_valid", 32'(rsp_valid), 32'h0);
      chk("idle_rdaddr", 32'(mem_rdaddr), 32'h0);
      chk("idle_ptr", 32'(dut.r_ptr), 32'h0);
      chk("idle_we", 32'(mem_we), 32'h0);
      step();
    end

    // single read
    req = 4'b0010;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'b0010);
    chk("t1_rdaddr", 32'(mem_rdaddr), 32'h2);
    step(); req = '0;
    @(negedge clk);
    chk("t1_valid", 32'(rsp_valid), 32'h1);
    chk("t1_id", 32'(rsp_id), 32'h1);
    chk("t1_data", 32'(rsp_data), 32'hA);
    chk("t1_ptr", 32'(dut.r_ptr), 32'h2);
    chk("t1_gnt_off", 32'(gnt), 32'h0);
    step();

    // fairness from reset
    rst_n = 1'b0;
    #1 chk("t2_rst_ptr", 32'(dut.r_ptr), 32'h0);
    step(); rst_n = 1'b1; req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_gnt", 32'(gnt), 32'(1 << (k % 4)));
      if (k > 0) begin
        chk("t2_valid", 32'(rsp_valid), 32'h1);
        chk("t2_id", 32'(rsp_id), 32'((k - 1) % 4));
      end
      step();
    end
    req = '0;
    @(negedge clk);
    chk("t2_last_valid", 32'(rsp_valid), 32'h1);
    chk("t2_last_id", 32'(rsp_id), 32'h3);
    chk("t2_ptr", 32'(dut.r_ptr), 32'h0);
    step();

    // wrap: bring ptr to 3, then req=0101
    req = 4'b0100;
    @(negedge clk);
    chk("t3_pre_gnt", 32'(gnt), 32'b0100);
    step(); req = 4'b0101;
    @(negedge clk);
    chk("t3_ptr3", 32'(dut.r_ptr), 32'h3);
    chk("t3_gnt_a", 32'(gnt), 32'b0001);
    step();
    @(negedge clk);
    chk("t3_gnt_b", 32'(gnt), 32'b0100);
    chk("t3_id_a", 32'(rsp_id), 32'h0);
    step(); req = '0;
    @(negedge clk);
    chk("t3_id_b", 32'(rsp_id), 32'h2);
    chk("t3_ptr_end", 32'(dut.r_ptr), 32'h3);
    step();

    // read/write collision on addr 1
    req = 4'b0001; req_addr = pk(2'd1, 2'd3, 2'd2, 2'd1);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h5;
    @(negedge clk);
    chk("t4_gnt", 32'(gnt), 32'b0001);
    chk("t4_rdaddr", 32'(mem_rdaddr), 32'h1);
    step(); wr_en = 1'b0; req = '0;
    @(negedge clk);
    chk("t4_valid", 32'(rsp_valid), 32'h1);
    chk("t4_id", 32'(rsp_id), 32'h0);
    chk("t4_col_data", 32'(rsp_data), 32'(col_exp));
    step(); req = 4'b0001;
    @(negedge clk);
    chk("t4_gnt2", 32'(gnt), 32'b0001);
    step(); req = '0;
    @(negedge clk);
    chk("t4_new_data", 32'(rsp_data), 32'h5);
    step();

    // reset in the response cycle drops it
    req = 4'b1000;
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'b1000);
    step(); req = '0;
    @(negedge clk);
    chk("t5_valid_pre", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0; req = 4'b1111;
    #1;
    chk("t5_valid_rst", 32'(rsp_valid), 32'h0);
    chk("t5_gnt_rst", 32'(gnt), 32'h0);
    chk("t5_ptr_rst", 32'(dut.r_ptr), 32'h0);
    step(); rst_n = 1'b1; req = 4'b1000;
    @(negedge clk);
    chk("t5_gnt_post", 32'(gnt), 32'b1000);
    chk("t5_valid_post", 32'(rsp_valid), 32'h0);
    step(); req = '0;
    @(negedge clk);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t5_rsp_id", 32'(rsp_id), 32'h3);
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
